// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register indices, sizing constants and the
// MAIN/SET/CLR/INV alias helpers used by the register block.
package gpio_pkg;

  typedef enum logic [1:0] {
    ACC_MAIN = 2'd0,
    ACC_SET  = 2'd1,
    ACC_CLR  = 2'd2,
    ACC_INV  = 2'd3
  } reg_access_t;

  typedef enum logic [2:0] {
    REG_OUT   = 3'd0,
    REG_DIR   = 3'd1,
    REG_IN    = 3'd2,
    REG_IE    = 3'd3,
    REG_IFLAG = 3'd4,
    REG_ISEL  = 3'd5
  } gpio_reg_t;

  localparam int GPIO_NUM_REGS = 6;
  localparam int GPIO_ADDR_W   = 5;

  // Control-register update: replace, OR in, mask out or toggle.
  function automatic logic [31:0] writeval(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input reg_access_t acc);
    logic [31:0] res;
    case (acc)
      ACC_MAIN: res = wdata;
      ACC_SET:  res = cur | wdata;
      ACC_CLR:  res = cur & ~wdata;
      default:  res = cur ^ wdata;
    endcase
    return res;
  endfunction

  // Flag-register update: bits can only be cleared, never set by software.
  function automatic logic [31:0] clearonly(input logic [31:0] cur,
                                            input logic [31:0] wdata,
                                            input reg_access_t acc);
    logic [31:0] res;
    case (acc)
      ACC_MAIN: res = cur & wdata;
      ACC_SET:  res = cur;
      default:  res = cur & ~wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchronizer: two flops into the clock domain, a previous-value
// register, and per-bit rising/falling event strobes.
import gpio_pkg::*;

module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  // Shift the pad value down the synchronizer chain each cycle.
  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Synchronizer and history flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = s2_q;
  assign rise     = s2_q & ~prev_q;
  assign fall     = ~s2_q & prev_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: OUT/DIR/IN/IE/IFLAG/ISEL registers behind a
// two-state request/ack bus, with edge-triggered interrupt flags.
import gpio_pkg::*;

module gpio_port #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [4:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACK  = 1'b1;

  logic             state_q, state_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] iflag_q, iflag_d;
  logic [WIDTH-1:0] isel_q, isel_d;

  logic [WIDTH-1:0] in_sync, rise, fall;
  logic             do_access, do_write;
  logic [2:0]       reg_idx;
  reg_access_t      acc;
  logic [31:0]      cur_val, wr_val, clr_val;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (gpio_in),
    .sync_out (in_sync),
    .rise     (rise),
    .fall     (fall)
  );

  // Decode the access, select the addressed register and compute next state.
  // The edge-event OR is applied after any software clear so a coincident
  // event always leaves its flag set.
  always_comb begin
    do_access = (state_q == ST_IDLE) && bus_req;
    do_write  = do_access && bus_we;
    reg_idx   = bus_addr[4:2];
    acc       = reg_access_t'(bus_addr[1:0]);

    cur_val = '0;
    case (reg_idx)
      REG_OUT:   cur_val[WIDTH-1:0] = out_q;
      REG_DIR:   cur_val[WIDTH-1:0] = dir_q;
      REG_IN:    cur_val[WIDTH-1:0] = in_sync;
      REG_IE:    cur_val[WIDTH-1:0] = ie_q;
      REG_IFLAG: cur_val[WIDTH-1:0] = iflag_q;
      REG_ISEL:  cur_val[WIDTH-1:0] = isel_q;
      default:   cur_val = '0;
    endcase

    wr_val  = writeval(cur_val, bus_wdata, acc);
    clr_val = clearonly(cur_val, bus_wdata, acc);

    out_d   = out_q;
    dir_d   = dir_q;
    ie_d    = ie_q;
    isel_d  = isel_q;
    iflag_d = iflag_q;
    if (do_write) begin
      case (reg_idx)
        REG_OUT:   out_d   = wr_val[WIDTH-1:0];
        REG_DIR:   dir_d   = wr_val[WIDTH-1:0];
        REG_IE:    ie_d    = wr_val[WIDTH-1:0];
        REG_ISEL:  isel_d  = wr_val[WIDTH-1:0];
        REG_IFLAG: iflag_d = clr_val[WIDTH-1:0];
        default:   ;
      endcase
    end
    iflag_d = iflag_d | (rise & ~isel_q) | (fall & isel_q);

    rdata_d = rdata_q;
    state_d = ST_IDLE;
    if (do_access) begin
      rdata_d = bus_we ? 32'h0 : cur_val;
      state_d = ST_ACK;
    end
  end

  // Register, bus FSM and read-data flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      out_q   <= '0;
      dir_q   <= '0;
      ie_q    <= '0;
      iflag_q <= '0;
      isel_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ie_q    <= ie_d;
      iflag_q <= iflag_d;
      isel_q  <= isel_d;
    end
  end

  assign bus_ack   = (state_q == ST_ACK);
  assign bus_rdata = rdata_q;
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = |(iflag_q & ie_q);

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: a vector table for plain register traffic
// plus hand-written sequences for edges, flag clearing, widths and reset.
module tb_gpio_port;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] gpio_in32 = '0;
  logic [7:0]  gpio_in8;

  logic [31:0] rdata32, rdata8;
  logic        ack32, ack8;
  logic [31:0] out32, oe32;
  logic [7:0]  out8, oe8;
  logic        irq32, irq8;

  int total = 0;
  int bad   = 0;

  vec_t vecs[10];

  assign gpio_in8 = gpio_in32[7:0];

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata32),
    .bus_ack(ack32), .gpio_in(gpio_in32), .gpio_out(out32),
    .gpio_oe(oe32), .irq(irq32)
  );

  gpio_port #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata8),
    .bus_ack(ack8), .gpio_in(gpio_in8), .gpio_out(out8),
    .gpio_oe(oe8), .irq(irq8)
  );

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // One bus transaction; returns both DUTs' read data captured while ack is high.
  task automatic doBus(input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata,
                       output logic [31:0] rd32, output logic [31:0] rd8);
    int n;
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack32 && n < 8);
    checkOutput("ack_latency", 32'(n), 32'd1);
    checkOutput("ack8_with_ack32", {31'b0, ack8}, 32'd1);
    rd32 = rdata32;
    rd8  = rdata8;
    @(negedge clk);
    bus_req = 1'b0;
    @(posedge clk); #1;
    checkOutput("ack_one_cycle", {31'b0, ack32}, 32'd0);
  endtask

  // Apply one table vector and check its expected outputs.
  task automatic applyStimulus(input int i);
    logic [31:0] r32, r8;
    doBus(vecs[i].we, vecs[i].addr, vecs[i].wdata, r32, r8);
    if (vecs[i].chk_rd) begin
      checkOutput($sformatf("vec%0d_rdata", i), r32, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_rdata8", i), r8, vecs[i].exp_rd & 32'hFF);
    end
    checkOutput($sformatf("vec%0d_out", i), out32, vecs[i].exp_out);
    checkOutput($sformatf("vec%0d_oe", i), oe32, vecs[i].exp_oe);
    checkOutput($sformatf("vec%0d_out8", i), {24'b0, out8}, vecs[i].exp_out & 32'hFF);
  endtask

  initial begin
    logic [31:0] r32, r8;

    // we, addr, wdata, chk_rd, exp_rd, exp_out, exp_oe
    vecs[0] = '{1'b1, 5'd0,  32'h0000_000F, 1'b0, 32'h0,   32'h0F,  32'h0};
    vecs[1] = '{1'b1, 5'd1,  32'h0000_00F0, 1'b0, 32'h0,   32'hFF,  32'h0};
    vecs[2] = '{1'b1, 5'd2,  32'h0000_0003, 1'b0, 32'h0,   32'hFC,  32'h0};
    vecs[3] = '{1'b1, 5'd3,  32'h0000_0101, 1'b0, 32'h0,   32'h1FD, 32'h0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 32'h1FD, 32'h1FD, 32'h0};
    vecs[5] = '{1'b0, 5'd3,  32'h0,         1'b1, 32'h1FD, 32'h1FD, 32'h0};
    vecs[6] = '{1'b1, 5'd4,  32'h0000_00A5, 1'b0, 32'h0,   32'h1FD, 32'hA5};
    vecs[7] = '{1'b1, 5'd6,  32'h0000_0081, 1'b0, 32'h0,   32'h1FD, 32'h24};
    vecs[8] = '{1'b1, 5'd28, 32'hFFFF_FFFF, 1'b0, 32'h0,   32'h1FD, 32'h24};
    vecs[9] = '{1'b0, 5'd24, 32'h0,         1'b1, 32'h0,   32'h1FD, 32'h24};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out", out32, 32'h0);
    checkOutput("reset_oe", oe32, 32'h0);
    checkOutput("reset_irq", {31'b0, irq32}, 32'h0);
    checkOutput("reset_ack", {31'b0, ack32}, 32'h0);
    checkOutput("reset_rdata", rdata32, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(i);

    // Rising edge on pad 3 flags two edges after the change; falling does not.
    doBus(1'b1, 5'd20, 32'h0, r32, r8);
    doBus(1'b1, 5'd12, 32'h0000_001C, r32, r8);
    checkOutput("irq_idle", {31'b0, irq32}, 32'h0);
    @(negedge clk);
    gpio_in32[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("irq_before_k2", {31'b0, irq32}, 32'h0);
    @(posedge clk); #1;
    checkOutput("irq_at_k2", {31'b0, irq32}, 32'h1);
    doBus(1'b0, 5'd16, 32'h0, r32, r8);
    checkOutput("iflag_rise3", r32, 32'h8);
    @(negedge clk);
    gpio_in32[3] = 1'b0;
    repeat (4) @(posedge clk);
    doBus(1'b0, 5'd16, 32'h0, r32, r8);
    checkOutput("iflag_after_fall", r32, 32'h8);

    // Flag clearing through the aliases.
    @(negedge clk);
    gpio_in32[4] = 1'b1;
    repeat (4) @(posedge clk);
    doBus(1'b0, 5'd16, 32'h0, r32, r8);
    checkOutput("iflag_18", r32, 32'h18);
    doBus(1'b1, 5'd16, 32'hFFFF_FFEF, r32, r8);
    doBus(1'b0, 5'd16, 32'h0, r32, r8);
    checkOutput("iflag_main_clr", r32, 32'h08);
    doBus(1'b1, 5'd17, 32'h0000_0010, r32, r8);
    doBus(1'b0, 5'd16, 32'h0, r32, r8);
    checkOutput("iflag_set_noop", r32, 32'h08);
    doBus(1'b1, 5'd18, 32'h0000_0008, r32, r8);
    doBus(1'b0, 5'd16, 32'h0, r32, r8);
    checkOutput("iflag_clr", r32, 32'h0);
    checkOutput("irq_cleared", {31'b0, irq32}, 32'h0);

    // CLR of bit 2 in the same cycle its rising event lands: set wins.
    @(negedge clk);
    gpio_in32[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 5'd18; bus_wdata = 32'h4;
    @(posedge clk); #1;
    checkOutput("coinc_ack", {31'b0, ack32}, 32'h1);
    @(negedge clk);
    bus_req = 1'b0;
    @(posedge clk); #1;
    doBus(1'b0, 5'd16, 32'h0, r32, r8);
    checkOutput("coinc_iflag", r32, 32'h4);
    checkOutput("coinc_irq", {31'b0, irq32}, 32'h1);

    // Width masking, reserved index and read-only IN.
    doBus(1'b1, 5'd4, 32'h0000_FFFF, r32, r8);
    doBus(1'b0, 5'd4, 32'h0, r32, r8);
    checkOutput("dir_w8", r8, 32'hFF);
    checkOutput("dir_w32", r32, 32'hFFFF);
    checkOutput("oe_w8", {24'b0, oe8}, 32'hFF);
    doBus(1'b0, 5'd24, 32'h0, r32, r8);
    checkOutput("reserved6_w8", r8, 32'h0);
    doBus(1'b1, 5'd8, 32'hFFFF_FFFF, r32, r8);
    doBus(1'b0, 5'd8, 32'h0, r32, r8);
    checkOutput("in_ro_w8", r8, 32'h14);
    checkOutput("in_ro_w32", r32, 32'h14);

    // Reset during the ack cycle aborts everything at once.
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 5'd0; bus_wdata = 32'h55;
    @(posedge clk); #1;
    checkOutput("pre_rst_ack", {31'b0, ack32}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst_ack", {31'b0, ack32}, 32'h0);
    checkOutput("rst_out", out32, 32'h0);
    checkOutput("rst_oe", oe32, 32'h0);
    checkOutput("rst_irq", {31'b0, irq32}, 32'h0);
    bus_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    doBus(1'b1, 5'd0, 32'h3C, r32, r8);
    checkOutput("post_rst_out", out32, 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
